// File: rtl/fsmc_motor_regs_if.sv
// FSMC slave-side bus bundle for fsmc_motor_regs.
//   fsmc_a    : bus address (ADDR_W bits)
//   fsmc_ne1  : chip enable, active low, asynchronous to the register clock
//   fsmc_nwe  : write strobe, active low, asynchronous
//   fsmc_noe  : output enable, active low, asynchronous
//   d_drive   : high while the slave drives the shared data bus (read window)
// The bidirectional data bus stays a plain inout port on the slave module.
//
// Handshake: a write is one low-going NWE pulse framed by NE1 low, and it is
// accepted on the NWE rising edge. A read is one low-going NOE pulse framed
// by NE1 low. The data returned is captured on the NOE falling edge and is
// held on the bus until NOE or NE1 goes high again. Address and write data
// must be stable from the strobe start until 3 clocks after its closing edge.
interface fsmc_motor_regs_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] fsmc_a;
  logic              fsmc_ne1;
  logic              fsmc_nwe;
  logic              fsmc_noe;
  logic              d_drive;

  modport master (
    output fsmc_a, fsmc_ne1, fsmc_nwe, fsmc_noe,
    input  d_drive
  );

  modport slave (
    input  fsmc_a, fsmc_ne1, fsmc_nwe, fsmc_noe,
    output d_drive
  );
endinterface

// File: rtl/fsmc_motor_regs.sv
// STM32 FSMC slave register bank for NCH motor channels.
// Strobes are synchronised into CLK, and each strobe performs exactly one access.
// PWM COUNT/DUTY values are double-buffered so that both bytes update atomically.
// Per-channel STAT is snapshotted on reads. Masked STAT bits set sticky
// write-1-to-clear FAULT bits, and FAULT_IRQ is the registered OR of all of them.
// Ports:
//   CLK, RST   : clock and asynchronous active-high reset
//   bus        : FSMC address and strobes (slave modport), plus the drive flag
//   FSMC_D     : 8-bit bidirectional data, driven only inside a read window
//   STAT_IN    : channel status, channel c at [c*8+:8]
//   CTRL       : channel control bytes
//   COUNT/DUTY : active 16-bit PWM period / duty per channel
//   FAULT_IRQ  : OR of all FAULT bits, registered
// Map per channel (base c*8): +0 CTRL, +1/+2 COUNT lo/hi, +3/+4 DUTY lo/hi,
// +5 STAT, +6 FAULT, +7 reserved.
// Global block (base NCH*8): +0 ID, +1 SCRATCH, +2 COMMIT, +3 FAULT_SUM.
module fsmc_motor_regs #(
  parameter int          NCH        = 3,
  parameter int          ADDR_W     = 5,
  parameter logic [15:0] COUNT_RST  = 16'd25000,
  parameter logic [7:0]  FAULT_MASK = 8'hC0,
  parameter logic [7:0]  ID         = 8'hB2
) (
  input  logic                CLK,
  input  logic                RST,
  fsmc_motor_regs_if.slave    bus,
  inout  wire  [7:0]          FSMC_D,
  input  logic [NCH*8-1:0]    STAT_IN,
  output logic [NCH*8-1:0]    CTRL,
  output logic [NCH*16-1:0]   COUNT,
  output logic [NCH*16-1:0]   DUTY,
  output logic                FAULT_IRQ
);

  localparam int G_BASE = NCH * 8;

  // Synchroniser chains: s1 and s2 are the two metastability flops. prev is
  // the s2 value from one cycle earlier and is used for edge detection.
  logic ne1_s1_q, ne1_s2_q, ne1_prev_q, ne1_s1_d, ne1_s2_d, ne1_prev_d;
  logic nwe_s1_q, nwe_s2_q, nwe_prev_q, nwe_s1_d, nwe_s2_d, nwe_prev_d;
  logic noe_s1_q, noe_s2_q, noe_prev_q, noe_s1_d, noe_s2_d, noe_prev_d;

  logic [7:0]  ctrl_q    [NCH];
  logic [7:0]  ctrl_d    [NCH];
  logic [15:0] count_q   [NCH];
  logic [15:0] count_d   [NCH];
  logic [15:0] duty_q    [NCH];
  logic [15:0] duty_d    [NCH];
  logic [7:0]  cnt_lo_q  [NCH];
  logic [7:0]  cnt_lo_d  [NCH];
  logic [7:0]  cnt_hi_q  [NCH];
  logic [7:0]  cnt_hi_d  [NCH];
  logic [7:0]  dty_lo_q  [NCH];
  logic [7:0]  dty_lo_d  [NCH];
  logic [7:0]  dty_hi_q  [NCH];
  logic [7:0]  dty_hi_d  [NCH];
  logic [7:0]  fault_q   [NCH];
  logic [7:0]  fault_d   [NCH];
  logic [7:0]  fault_clr [NCH];
  logic [7:0]  scratch_q, scratch_d;
  logic [7:0]  rd_q, rd_d;
  logic        irq_q, irq_d;

  logic                wr_stb, rd_stb, d_drive;
  logic [ADDR_W-4:0]   a_ch;
  logic [2:0]          a_off;
  int                  g_off;
  logic                g_hit;
  logic [7:0]          wdata, rd_val, fault_sum;

  always_comb begin
    ne1_s1_d   = bus.fsmc_ne1;
    ne1_s2_d   = ne1_s1_q;
    ne1_prev_d = ne1_s2_q;
    nwe_s1_d   = bus.fsmc_nwe;
    nwe_s2_d   = nwe_s1_q;
    nwe_prev_d = nwe_s2_q;
    noe_s1_d   = bus.fsmc_noe;
    noe_s2_d   = noe_s1_q;
    noe_prev_d = noe_s2_q;

    // NE1 usually rises together with NWE. The enable is therefore qualified
    // by its value one cycle earlier, which is aligned with the low half of
    // the NWE edge detector.
    wr_stb = nwe_s2_q & ~nwe_prev_q & ~ne1_prev_q;
    rd_stb = ~noe_s2_q & noe_prev_q & ~ne1_s2_q;
    // The drive window opens on the cycle rd_q is loaded, so stale data is
    // never presented. It closes as soon as either synchronised strobe goes high.
    d_drive = ~ne1_s2_q & ~noe_s2_q & ~noe_prev_q;

    a_ch  = bus.fsmc_a[ADDR_W-1:3];
    a_off = bus.fsmc_a[2:0];
    g_off = int'(bus.fsmc_a) - G_BASE;
    g_hit = (g_off >= 0) && (g_off < 4);
    wdata = FSMC_D;

    fault_sum = '0;
    for (int c = 0; c < NCH; c++) fault_sum[c] = |fault_q[c];

    // Read mux. Channel indices >= NCH never match and read as zero.
    rd_val = '0;
    for (int c = 0; c < NCH; c++) begin
      if (int'(a_ch) == c) begin
        case (a_off)
          3'd0:    rd_val = ctrl_q[c];
          3'd1:    rd_val = count_q[c][7:0];
          3'd2:    rd_val = count_q[c][15:8];
          3'd3:    rd_val = duty_q[c][7:0];
          3'd4:    rd_val = duty_q[c][15:8];
          3'd5:    rd_val = STAT_IN[c*8 +: 8];
          3'd6:    rd_val = fault_q[c];
          default: rd_val = '0;
        endcase
      end
    end
    if (g_hit) begin
      case (g_off[1:0])
        2'd0:    rd_val = ID;
        2'd1:    rd_val = scratch_q;
        2'd3:    rd_val = fault_sum;
        default: rd_val = '0;
      endcase
    end
    rd_d = rd_stb ? rd_val : rd_q;

    ctrl_d    = ctrl_q;
    count_d   = count_q;
    duty_d    = duty_q;
    cnt_lo_d  = cnt_lo_q;
    cnt_hi_d  = cnt_hi_q;
    dty_lo_d  = dty_lo_q;
    dty_hi_d  = dty_hi_q;
    scratch_d = scratch_q;
    for (int c = 0; c < NCH; c++) fault_clr[c] = '0;

    if (wr_stb) begin
      for (int c = 0; c < NCH; c++) begin
        if (int'(a_ch) == c) begin
          case (a_off)
            3'd0: ctrl_d[c] = wdata;
            3'd1: cnt_lo_d[c] = wdata;
            3'd2: begin
              cnt_hi_d[c] = wdata;
              count_d[c]  = {wdata, cnt_lo_q[c]};
            end
            3'd3: dty_lo_d[c] = wdata;
            3'd4: begin
              dty_hi_d[c] = wdata;
              duty_d[c]   = {wdata, dty_lo_q[c]};
            end
            3'd6:    fault_clr[c] = wdata;
            default: ;
          endcase
        end
      end
      if (g_hit && g_off[1:0] == 2'd1) scratch_d = wdata;
      if (g_hit && g_off[1:0] == 2'd2) begin
        for (int c = 0; c < NCH; c++) begin
          if (wdata[c]) begin
            count_d[c] = {cnt_hi_q[c], cnt_lo_q[c]};
            duty_d[c]  = {dty_hi_q[c], dty_lo_q[c]};
          end
        end
      end
    end

    // A set and a clear of the same bit in the same cycle leave the bit set.
    for (int c = 0; c < NCH; c++)
      fault_d[c] = (fault_q[c] & ~fault_clr[c]) | (STAT_IN[c*8 +: 8] & FAULT_MASK);

    irq_d = |fault_sum;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ne1_s1_q   <= 1'b1;
      ne1_s2_q   <= 1'b1;
      ne1_prev_q <= 1'b1;
      nwe_s1_q   <= 1'b1;
      nwe_s2_q   <= 1'b1;
      nwe_prev_q <= 1'b1;
      noe_s1_q   <= 1'b1;
      noe_s2_q   <= 1'b1;
      noe_prev_q <= 1'b1;
      for (int c = 0; c < NCH; c++) begin
        ctrl_q[c]   <= '0;
        count_q[c]  <= COUNT_RST;
        duty_q[c]   <= '0;
        cnt_lo_q[c] <= COUNT_RST[7:0];
        cnt_hi_q[c] <= COUNT_RST[15:8];
        dty_lo_q[c] <= '0;
        dty_hi_q[c] <= '0;
        fault_q[c]  <= '0;
      end
      scratch_q <= '0;
      rd_q      <= '0;
      irq_q     <= 1'b0;
    end else begin
      ne1_s1_q   <= ne1_s1_d;
      ne1_s2_q   <= ne1_s2_d;
      ne1_prev_q <= ne1_prev_d;
      nwe_s1_q   <= nwe_s1_d;
      nwe_s2_q   <= nwe_s2_d;
      nwe_prev_q <= nwe_prev_d;
      noe_s1_q   <= noe_s1_d;
      noe_s2_q   <= noe_s2_d;
      noe_prev_q <= noe_prev_d;
      ctrl_q     <= ctrl_d;
      count_q    <= count_d;
      duty_q     <= duty_d;
      cnt_lo_q   <= cnt_lo_d;
      cnt_hi_q   <= cnt_hi_d;
      dty_lo_q   <= dty_lo_d;
      dty_hi_q   <= dty_hi_d;
      fault_q    <= fault_d;
      scratch_q  <= scratch_d;
      rd_q       <= rd_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    CTRL  = '0;
    COUNT = '0;
    DUTY  = '0;
    for (int c = 0; c < NCH; c++) begin
      CTRL[c*8 +: 8]   = ctrl_q[c];
      COUNT[c*16 +: 16] = count_q[c];
      DUTY[c*16 +: 16]  = duty_q[c];
    end
  end

  assign FAULT_IRQ   = irq_q;
  assign bus.d_drive = d_drive;
  assign FSMC_D      = d_drive ? rd_q : 8'bz;

endmodule
